// File: rtl/if_fetch_unit.sv
// Instruction fetch stage: owns the PC, fetches over a req/ack memory handshake
// and holds one fetched instruction for the IF/ID register.
module if_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        start_i,
  input  logic        stall_i,
  input  logic        branch_i,
  input  logic [31:0] branch_target_i,
  output logic        imem_req_o,
  output logic [31:0] imem_addr_o,
  input  logic        imem_ack_i,
  input  logic [31:0] imem_data_i,
  output logic [31:0] ins_o,
  output logic [31:0] pc_o,
  output logic        valid_o
);

  localparam int unsigned XLEN = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    FULL = 2'd2
  } state_t;

  state_t          state;
  logic [XLEN-1:0] pcQ;
  logic            drop;

  logic [XLEN-1:0] target;
  logic [XLEN-1:0] nextPc;

  // Word-aligned redirect target; the fetch PC chosen for any request issued this edge.
  assign target = branch_target_i & ~XLEN'(3);
  assign nextPc = branch_i ? target : pcQ;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state       <= IDLE;
      pcQ         <= RESET_PC & ~XLEN'(3);
      drop        <= 1'b0;
      imem_req_o  <= 1'b0;
      imem_addr_o <= '0;
      valid_o     <= 1'b0;
      ins_o       <= '0;
      pc_o        <= '0;
    end else begin
      case (state)
        IDLE: begin
          pcQ <= nextPc;
          if (start_i) begin
            state       <= REQ;
            imem_req_o  <= 1'b1;
            imem_addr_o <= nextPc;
          end
        end

        REQ: begin
          if (imem_ack_i) begin
            drop <= 1'b0;
            if (drop || branch_i) begin
              // Wrong-path response: throw it away and refetch from the current PC.
              pcQ <= nextPc;
              if (start_i) begin
                imem_addr_o <= nextPc;
              end else begin
                imem_req_o <= 1'b0;
                state      <= IDLE;
              end
            end else begin
              ins_o      <= imem_data_i;
              pc_o       <= imem_addr_o;
              valid_o    <= 1'b1;
              pcQ        <= imem_addr_o + XLEN'(4);
              imem_req_o <= 1'b0;
              state      <= FULL;
            end
          end else if (branch_i) begin
            // Request cannot be withdrawn; mark its eventual response as stale.
            drop <= 1'b1;
            pcQ  <= target;
          end
        end

        FULL: begin
          if (branch_i || !stall_i) begin
            valid_o <= 1'b0;
            ins_o   <= '0;
            pc_o    <= '0;
            pcQ     <= nextPc;
            if (start_i) begin
              state       <= REQ;
              imem_req_o  <= 1'b1;
              imem_addr_o <= nextPc;
            end else begin
              state <= IDLE;
            end
          end
        end

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_if_fetch_unit.sv
// Bench for if_fetch_unit: directed scenarios plus a randomized run checked
// against a PC-stream reference model and a synthetic instruction memory.
`timescale 1ns/1ps
module tb_if_fetch_unit;

  logic        clk;
  logic        rst, start, stall, branch, ack;
  logic [31:0] target, data;
  logic        reqO, validO;
  logic [31:0] addrO, insO, pcO;

  logic        rstW, startW, ackW;
  logic [31:0] dataW;
  logic        reqW, validW;
  logic [31:0] addrW, insW, pcW;

  int checks, errors;
  bit memEn;
  int memLat, memCnt;

  if_fetch_unit dut (
    .clk_i(clk), .rst_i(rst), .start_i(start), .stall_i(stall),
    .branch_i(branch), .branch_target_i(target),
    .imem_req_o(reqO), .imem_addr_o(addrO),
    .imem_ack_i(ack), .imem_data_i(data),
    .ins_o(insO), .pc_o(pcO), .valid_o(validO)
  );

  if_fetch_unit #(.RESET_PC(32'hFFFF_FFFC)) dutW (
    .clk_i(clk), .rst_i(rstW), .start_i(startW), .stall_i(1'b0),
    .branch_i(1'b0), .branch_target_i(32'h0),
    .imem_req_o(reqW), .imem_addr_o(addrW),
    .imem_ack_i(ackW), .imem_data_i(dataW),
    .ins_o(insW), .pc_o(pcW), .valid_o(validW)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Synthetic instruction memory contents.
  function automatic logic [31:0] memWord(input logic [31:0] a);
    return {~a[15:0], a[15:0]} ^ 32'h5A00_00A5;
  endfunction

  // Advance to the next negedge and let the memory decide its ack for the coming posedge.
  task automatic tick();
    @(negedge clk);
    ack  = 1'b0;
    data = 32'h0;
    if (memEn && reqO === 1'b1) begin
      if (memCnt >= memLat) begin
        ack    = 1'b1;
        data   = memWord(addrO);
        memCnt = 0;
      end else begin
        memCnt++;
      end
    end else begin
      memCnt = 0;
    end
  endtask

  task automatic doReset();
    rst = 1'b1; start = 1'b0; stall = 1'b0; branch = 1'b0; target = 32'h0; memEn = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    doReset();
    checks++; if (reqO !== 1'b0 || validO !== 1'b0) begin errors++; $display("FAIL reset_flags got req=%b valid=%b want 0 0", reqO, validO); end
    checks++; if (addrO !== 32'h0) begin errors++; $display("FAIL reset_addr got %h want 00000000", addrO); end
    checks++; if (insO !== 32'h0 || pcO !== 32'h0) begin errors++; $display("FAIL reset_ins_pc got %h %h want 0 0", insO, pcO); end
    tick();
    tick();
    checks++; if (reqO !== 1'b0) begin errors++; $display("FAIL idle_no_start got req=%b want 0", reqO); end
  endtask

  task automatic test_sequential();
    logic [31:0] reqs[$];
    logic [31:0] pcs[$];
    logic [31:0] inss[$];
    logic prevReq;
    doReset();
    memLat = 2; start = 1'b1; prevReq = 1'b0;
    for (int i = 0; i < 60 && pcs.size() < 3; i++) begin
      tick();
      if (reqO === 1'b1 && !prevReq) reqs.push_back(addrO);
      if (validO === 1'b1) begin pcs.push_back(pcO); inss.push_back(insO); end
      prevReq = (reqO === 1'b1);
    end
    start = 1'b0;
    checks++; if (pcs.size() != 3) begin errors++; $display("FAIL seq_count got %0d want 3", pcs.size()); end
    for (int k = 0; k < 3; k++) begin
      logic [31:0] e;
      e = 32'(4 * k);
      checks++; if (k >= reqs.size() || reqs[k] !== e) begin errors++; $display("FAIL seq_req_addr idx %0d want %h", k, e); end
      checks++; if (k >= pcs.size() || pcs[k] !== e || inss[k] !== memWord(e)) begin errors++; $display("FAIL seq_delivery idx %0d want pc %h ins %h", k, e, memWord(e)); end
    end
  endtask

  task automatic test_stall();
    logic [31:0] ins0, pc0;
    doReset();
    memLat = 1; start = 1'b1;
    for (int i = 0; i < 30 && validO !== 1'b1; i++) tick();
    ins0 = insO; pc0 = pcO;
    checks++; if (validO !== 1'b1 || pc0 !== 32'h0 || ins0 !== memWord(32'h0)) begin errors++; $display("FAIL stall_first got v=%b pc=%h ins=%h want 1 0 %h", validO, pc0, ins0, memWord(32'h0)); end
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++; if (validO !== 1'b1 || insO !== ins0 || pcO !== pc0) begin errors++; $display("FAIL stall_hold cyc %0d got v=%b pc=%h ins=%h", i, validO, pcO, insO); end
      checks++; if (reqO !== 1'b0) begin errors++; $display("FAIL stall_no_req cyc %0d got %b want 0", i, reqO); end
    end
    stall = 1'b0;
    tick();
    start = 1'b0;
    checks++; if (validO !== 1'b0) begin errors++; $display("FAIL stall_consume got v=%b want 0", validO); end
    checks++; if (reqO !== 1'b1 || addrO !== 32'h4) begin errors++; $display("FAIL stall_resume got req=%b addr=%h want 1 00000004", reqO, addrO); end
  endtask

  task automatic test_branch_req();
    logic [31:0] newAddr, firstPc, firstIns;
    bit got;
    doReset();
    memLat = 1; start = 1'b1;
    for (int i = 0; i < 40 && !(reqO === 1'b1 && addrO === 32'h8); i++) tick();
    checks++; if (reqO !== 1'b1 || addrO !== 32'h8) begin errors++; $display("FAIL br_reach got req=%b addr=%h want 1 00000008", reqO, addrO); end
    memLat = 4; branch = 1'b1; target = 32'h43;
    tick();
    branch = 1'b0;
    checks++; if (reqO !== 1'b1 || addrO !== 32'h8) begin errors++; $display("FAIL br_req_held got req=%b addr=%h want 1 00000008", reqO, addrO); end
    newAddr = 32'h8; firstPc = 32'hFFFF_FFFF; firstIns = 32'h0; got = 1'b0;
    for (int i = 0; i < 40 && !got; i++) begin
      tick();
      if (reqO === 1'b1 && addrO !== 32'h8 && newAddr === 32'h8) newAddr = addrO;
      if (validO === 1'b1) begin got = 1'b1; firstPc = pcO; firstIns = insO; end
    end
    start = 1'b0;
    checks++; if (newAddr !== 32'h40) begin errors++; $display("FAIL br_next_req got %h want 00000040", newAddr); end
    checks++; if (firstPc !== 32'h40) begin errors++; $display("FAIL br_first_pc got %h want 00000040", firstPc); end
    checks++; if (firstIns !== memWord(32'h40)) begin errors++; $display("FAIL br_first_ins got %h want %h", firstIns, memWord(32'h40)); end
  endtask

  task automatic test_branch_stall_full();
    doReset();
    memLat = 1; start = 1'b1;
    for (int i = 0; i < 30 && validO !== 1'b1; i++) tick();
    stall = 1'b1; branch = 1'b1; target = 32'h100;
    tick();
    branch = 1'b0; stall = 1'b0;
    checks++; if (validO !== 1'b0 || insO !== 32'h0 || pcO !== 32'h0) begin errors++; $display("FAIL bsf_flush got v=%b pc=%h ins=%h want 0 0 0", validO, pcO, insO); end
    checks++; if (reqO !== 1'b1 || addrO !== 32'h100) begin errors++; $display("FAIL bsf_req got req=%b addr=%h want 1 00000100", reqO, addrO); end
    for (int i = 0; i < 30 && validO !== 1'b1; i++) tick();
    start = 1'b0;
    checks++; if (validO !== 1'b1 || pcO !== 32'h100 || insO !== memWord(32'h100)) begin errors++; $display("FAIL bsf_deliver got v=%b pc=%h ins=%h want 1 00000100 %h", validO, pcO, insO, memWord(32'h100)); end
  endtask

  task automatic test_reset_mid_req();
    doReset();
    memLat = 6; start = 1'b1;
    for (int i = 0; i < 10 && reqO !== 1'b1; i++) tick();
    checks++; if (reqO !== 1'b1 || addrO !== 32'h0) begin errors++; $display("FAIL rmr_req got req=%b addr=%h want 1 0", reqO, addrO); end
    memEn = 1'b0; rst = 1'b1; start = 1'b0;
    tick();
    rst = 1'b0; ack = 1'b1; data = 32'hDEAD_BEEF;
    tick();
    checks++; if ({reqO, validO, addrO, insO, pcO} !== 98'h0) begin errors++; $display("FAIL rmr_ack_ignored got req=%b v=%b addr=%h ins=%h pc=%h want all 0", reqO, validO, addrO, insO, pcO); end
    tick();
    checks++; if (reqO !== 1'b0 || validO !== 1'b0) begin errors++; $display("FAIL rmr_quiet got req=%b v=%b want 0 0", reqO, validO); end
    memEn = 1'b1; memLat = 1; start = 1'b1;
    for (int i = 0; i < 10 && reqO !== 1'b1; i++) tick();
    checks++; if (reqO !== 1'b1 || addrO !== 32'h0) begin errors++; $display("FAIL rmr_restart got req=%b addr=%h want 1 0", reqO, addrO); end
    for (int i = 0; i < 10 && validO !== 1'b1; i++) tick();
    start = 1'b0;
    checks++; if (validO !== 1'b1 || pcO !== 32'h0 || insO !== memWord(32'h0)) begin errors++; $display("FAIL rmr_deliver got v=%b pc=%h ins=%h want 1 0 %h", validO, pcO, insO, memWord(32'h0)); end
  endtask

  task automatic test_wrap();
    rstW = 1'b1; startW = 1'b0; ackW = 1'b0; dataW = 32'h0;
    @(negedge clk);
    @(negedge clk);
    rstW = 1'b0; startW = 1'b1;
    @(negedge clk);
    checks++; if (reqW !== 1'b1 || addrW !== 32'hFFFF_FFFC) begin errors++; $display("FAIL wrap_first_req got req=%b addr=%h want 1 fffffffc", reqW, addrW); end
    ackW = 1'b1; dataW = 32'h1234_5678;
    @(negedge clk);
    ackW = 1'b0; dataW = 32'h0;
    checks++; if (validW !== 1'b1 || pcW !== 32'hFFFF_FFFC || insW !== 32'h1234_5678) begin errors++; $display("FAIL wrap_first_ins got v=%b pc=%h ins=%h want 1 fffffffc 12345678", validW, pcW, insW); end
    @(negedge clk);
    checks++; if (reqW !== 1'b1 || addrW !== 32'h0 || validW !== 1'b0) begin errors++; $display("FAIL wrap_second_req got req=%b addr=%h v=%b want 1 0 0", reqW, addrW, validW); end
    startW = 1'b0; ackW = 1'b1; dataW = 32'hCAFE_0001;
    @(negedge clk);
    ackW = 1'b0; dataW = 32'h0;
    checks++; if (validW !== 1'b1 || pcW !== 32'h0 || insW !== 32'hCAFE_0001) begin errors++; $display("FAIL wrap_second_ins got v=%b pc=%h ins=%h want 1 0 cafe0001", validW, pcW, insW); end
  endtask

  // Reference model: the next delivered PC is the last redirect target, advanced by 4 per consumed instruction.
  task automatic test_random();
    logic [31:0] expPc, prevAddr;
    logic prevReq, prevAck;
    int delivered;
    doReset();
    expPc = 32'h0; prevReq = 1'b0; prevAck = 1'b0; prevAddr = 32'h0; delivered = 0;
    for (int i = 0; i < 2000; i++) begin
      tick();
      if (validO === 1'b1) begin
        delivered++;
        checks++; if (pcO !== expPc) begin errors++; $display("FAIL rand_pc cyc %0d got %h want %h", i, pcO, expPc); end
        checks++; if (insO !== memWord(expPc)) begin errors++; $display("FAIL rand_ins cyc %0d got %h want %h", i, insO, memWord(expPc)); end
      end else begin
        checks++; if (insO !== 32'h0 || pcO !== 32'h0) begin errors++; $display("FAIL rand_bubble cyc %0d got ins=%h pc=%h want 0 0", i, insO, pcO); end
      end
      checks++; if (addrO[1:0] !== 2'b00) begin errors++; $display("FAIL rand_align cyc %0d got %h", i, addrO); end
      if (prevReq && !prevAck) begin
        checks++; if (reqO !== 1'b1 || addrO !== prevAddr) begin errors++; $display("FAIL rand_req_stable cyc %0d got req=%b addr=%h want 1 %h", i, reqO, addrO, prevAddr); end
      end
      if (i % 64 == 0) memLat = int'($urandom_range(0, 3));
      stall  = ($urandom_range(0, 99) < 30);
      branch = ($urandom_range(0, 99) < 8);
      start  = ($urandom_range(0, 99) < 90);
      target = $urandom;
      if (branch) expPc = target & ~32'h3;
      else if (validO === 1'b1 && !stall) expPc = expPc + 32'd4;
      prevReq = (reqO === 1'b1); prevAddr = addrO; prevAck = ack;
    end
    stall = 1'b0; branch = 1'b0; start = 1'b0;
    checks++; if (delivered < 50) begin errors++; $display("FAIL rand_progress got %0d deliveries want >= 50", delivered); end
  endtask

  initial begin
    checks = 0; errors = 0;
    rst = 1'b1; start = 1'b0; stall = 1'b0; branch = 1'b0; target = 32'h0;
    ack = 1'b0; data = 32'h0; memEn = 1'b1; memLat = 1; memCnt = 0;
    rstW = 1'b1; startW = 1'b0; ackW = 1'b0; dataW = 32'h0;
    test_reset();
    test_sequential();
    test_stall();
    test_branch_req();
    test_branch_stall_full();
    test_reset_mid_req();
    test_wrap();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
